// File: rtl/regfile_sb.sv
// Parametrised register file with per-register busy scoreboard and a handshaked dump engine.
// Optional REGFILE_BYPASS_EN: write-through forwarding of wr_data to the read and dump ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            dump_req,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_addr,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_done
);

  localparam int NREG = 2 ** AW;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [XLEN-1:0] regs_reg [1:NREG-1];
  logic            busy_reg [1:NREG-1];
  logic [XLEN-1:0] rd_vec   [NREG];
  logic [NREG-1:0] busy_vec;

  state_t          state_reg;
  logic            dump_valid_reg;
  logic            dump_done_reg;
  logic [AW-1:0]   dump_addr_reg;

  logic            wr_live;

  assign rd_vec[0]   = '0;
  assign busy_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      // Issue beats write-back on the same index: a newer producer is in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_reg[gi] <= '0;
          busy_reg[gi] <= 1'b0;
        end else begin
          if (wr_en && wr_addr == AW'(gi)) begin
            regs_reg[gi] <= wr_data;
          end
          if (iss_en && iss_addr == AW'(gi)) begin
            busy_reg[gi] <= 1'b1;
          end else if (wr_en && wr_addr == AW'(gi)) begin
            busy_reg[gi] <= 1'b0;
          end
        end
      end

      assign rd_vec[gi]   = regs_reg[gi];
      assign busy_vec[gi] = busy_reg[gi];
    end
  endgenerate

  assign wr_live = BYPASS && wr_en && (wr_addr != '0);

  assign rs1_data  = (wr_live && rs1_addr == wr_addr) ? wr_data : rd_vec[rs1_addr];
  assign rs2_data  = (wr_live && rs2_addr == wr_addr) ? wr_data : rd_vec[rs2_addr];
  assign dump_data = (wr_live && dump_addr_reg == wr_addr) ? wr_data : rd_vec[dump_addr_reg];

  assign rs1_busy = busy_vec[rs1_addr];
  assign rs2_busy = busy_vec[rs2_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      dump_valid_reg <= 1'b0;
      dump_done_reg  <= 1'b0;
      dump_addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          dump_done_reg <= 1'b0;
          if (dump_req) begin
            dump_addr_reg  <= '0;
            dump_valid_reg <= 1'b1;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          if (dump_ready) begin
            if (dump_addr_reg == AW'(NREG - 1)) begin
              dump_valid_reg <= 1'b0;
              dump_done_reg  <= 1'b1;
              state_reg      <= DONE;
            end else begin
              dump_addr_reg <= dump_addr_reg + AW'(1);
            end
          end
        end
        DONE: begin
          dump_done_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          dump_valid_reg <= 1'b0;
          dump_done_reg  <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign dump_valid = dump_valid_reg;
  assign dump_done  = dump_done_reg;
  assign dump_addr  = dump_addr_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: default 32x32 instance plus a 64-bit, 16-entry instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_addr, dump_addr;
  logic [31:0] rs1_data, rs2_data, wr_data, dump_data;
  logic        rs1_busy, rs2_busy, wr_en, iss_en;
  logic        dump_req, dump_valid, dump_ready, dump_done;

  logic [3:0]  p_rs1_addr, p_rs2_addr, p_wr_addr, p_iss_addr, p_dump_addr;
  logic [63:0] p_rs1_data, p_rs2_data, p_wr_data, p_dump_data;
  logic        p_rs1_busy, p_rs2_busy, p_wr_en, p_iss_en;
  logic        p_dump_req, p_dump_valid, p_dump_ready, p_dump_done;

  int checks = 0;
  int errors = 0;

  logic [4:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic [3:0]  exp_addr64_q [$];
  logic [63:0] exp_data64_q [$];

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  regfile_sb #(.XLEN(64), .AW(4)) dut64 (
    .clk(clk), .rst(rst),
    .rs1_addr(p_rs1_addr), .rs2_addr(p_rs2_addr),
    .rs1_data(p_rs1_data), .rs2_data(p_rs2_data),
    .rs1_busy(p_rs1_busy), .rs2_busy(p_rs2_busy),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .iss_en(p_iss_en), .iss_addr(p_iss_addr),
    .dump_req(p_dump_req), .dump_valid(p_dump_valid), .dump_ready(p_dump_ready),
    .dump_addr(p_dump_addr), .dump_data(p_dump_data), .dump_done(p_dump_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rs1_addr = '0; rs2_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; dump_req = 1'b0; dump_ready = 1'b0;
    p_rs1_addr = '0; p_rs2_addr = '0; p_wr_en = 1'b0; p_wr_addr = '0; p_wr_data = '0;
    p_iss_en = 1'b0; p_iss_addr = '0; p_dump_req = 1'b0; p_dump_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle_inputs();
    rs1_addr = 5'd9;
    tick(); tick();
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid: got %b expected 0", dump_valid); end
    checks++; if (dump_addr !== 5'd0) begin errors++; $display("FAIL reset_dump_addr: got %0d expected 0", dump_addr); end
    checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_dump_done: got %b expected 0", dump_done); end
    checks++; if (rs1_data !== 32'd0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_x9: got %h/%b expected 0/0", rs1_data, rs1_busy); end
    rst = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    exp_data_q.push_back(32'hDEADBEEF);
    tick();
    wr_en = 1'b0; rs1_addr = 5'd5;
    #1;
    checks++; if (rs1_data !== exp_data_q[0]) begin errors++; $display("FAIL reset_pre_x5: got %h expected %h", rs1_data, exp_data_q[0]); end
    void'(exp_data_q.pop_front());
    #2 rst = 1'b0;
    #1;
    checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL reset_async_x5: got %h expected 0", rs1_data); end
    $display("reset: async clear of x5 -> %h", rs1_data);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_x0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0; rs1_addr = 5'd0;
    #1;
    checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL x0_same_cycle: got %h expected 0", rs1_data); end
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL x0_data: got %h expected 0", rs1_data); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", rs1_busy); end
    $display("x0: data %h busy %b", rs1_data, rs1_busy);
  endtask

  task automatic test_scoreboard;
    iss_en = 1'b1; iss_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_before_edge: got %b expected 0", rs2_busy); end
    tick();
    iss_en = 1'b0;
    #1;
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_issue: got %b expected 1", rs2_busy); end
    iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b expected 1", rs2_busy); end
    checks++; if (rs2_data !== 32'h77) begin errors++; $display("FAIL sb_set_wins_data: got %h expected 00000077", rs2_data); end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0;
    #1;
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b expected 0", rs2_busy); end
    checks++; if (rs2_data !== 32'h1234) begin errors++; $display("FAIL sb_clear_data: got %h expected 00001234", rs2_data); end
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    iss_addr = 5'd8; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h99;
    tick();
    iss_en = 1'b0; wr_en = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd8;
    #1;
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_split: got %b/%b expected 0/1", rs1_busy, rs2_busy); end
    checks++; if (rs1_data !== 32'h99) begin errors++; $display("FAIL sb_split_data: got %h expected 00000099", rs1_data); end
    $display("scoreboard: x7 busy %b data %h, x8 busy %b", rs1_busy, rs1_data, rs2_busy);
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'd0;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_bypass;
    logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 32'h12345678;
`else
    exp = 32'h0;
`endif
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    checks++; if (rs1_data !== exp) begin errors++; $display("FAIL bypass_rs1: got %h expected %h", rs1_data, exp); end
    checks++; if (rs2_data !== exp) begin errors++; $display("FAIL bypass_rs2: got %h expected %h", rs2_data, exp); end
    tick();
    wr_en = 1'b0;
    #1;
    checks++; if (rs1_data !== 32'h12345678) begin errors++; $display("FAIL bypass_after: got %h expected 12345678", rs1_data); end
    $display("bypass: same-cycle %h, next-cycle %h", exp, rs1_data);
  endtask

  task automatic test_dump_backpressure;
    int done_cnt;
    int post;
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 4);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_addr_q.push_back(5'(i));
      exp_data_q.push_back(32'(i * 4));
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    done_cnt = 0;
    post = 0;
    for (int cyc = 0; cyc < 200 && post < 6; cyc++) begin
      dump_ready = (cyc % 2) == 1;
      dump_req = (cyc == 5);
      #1;
      if (dump_done === 1'b1) begin
        done_cnt++;
        checks++; if (exp_addr_q.size() != 0 || dump_valid !== 1'b0) begin errors++; $display("FAIL dump_done_early: left %0d valid %b expected 0/0", exp_addr_q.size(), dump_valid); end
        $display("dump: done pulse at cycle %0d", cyc);
      end
      if (dump_valid === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dump_extra_beat: got addr %0d expected no beat", dump_addr);
        end else begin
          checks++; if (dump_addr !== exp_addr_q[0]) begin errors++; $display("FAIL dump_addr: got %0d expected %0d", dump_addr, exp_addr_q[0]); end
          checks++; if (dump_data !== exp_data_q[0]) begin errors++; $display("FAIL dump_data: got %h expected %h", dump_data, exp_data_q[0]); end
          if (dump_ready) begin
            $display("dump: beat addr %0d data %h", dump_addr, dump_data);
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
          end
        end
      end
      if (exp_addr_q.size() == 0 && done_cnt > 0) post++;
      tick();
    end
    dump_ready = 1'b0; dump_req = 1'b0;
    checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL dump_timeout: got %0d beats left expected 0", exp_addr_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dump_done_count: got %0d expected 1", done_cnt); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL dump_req_ignored: got valid %b expected 0", dump_valid); end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_param;
    int done_cnt;
    int post;
    logic [3:0] last_addr;
    p_wr_en = 1'b1; p_wr_addr = 4'd15; p_wr_data = 64'hA5A5_A5A5_5A5A_5A5A;
    tick();
    p_wr_en = 1'b0; p_rs1_addr = 4'd15;
    #1;
    checks++; if (p_rs1_data !== 64'hA5A5_A5A5_5A5A_5A5A) begin errors++; $display("FAIL p64_read: got %h expected a5a5a5a55a5a5a5a", p_rs1_data); end
    for (int i = 0; i < 16; i++) begin
      exp_addr64_q.push_back(4'(i));
      exp_data64_q.push_back((i == 15) ? 64'hA5A5_A5A5_5A5A_5A5A : 64'd0);
    end
    p_dump_req = 1'b1;
    tick();
    p_dump_req = 1'b0; p_dump_ready = 1'b1;
    done_cnt = 0; post = 0; last_addr = '0;
    for (int cyc = 0; cyc < 100 && post < 3; cyc++) begin
      #1;
      if (p_dump_done === 1'b1) done_cnt++;
      if (p_dump_valid === 1'b1) begin
        if (exp_addr64_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL p64_extra_beat: got addr %0d expected no beat", p_dump_addr);
        end else begin
          checks++; if (p_dump_addr !== exp_addr64_q[0] || p_dump_data !== exp_data64_q[0]) begin
            errors++; $display("FAIL p64_beat: got %0d/%h expected %0d/%h", p_dump_addr, p_dump_data, exp_addr64_q[0], exp_data64_q[0]);
          end
          $display("p64 dump: beat addr %0d data %h", p_dump_addr, p_dump_data);
          last_addr = p_dump_addr;
          void'(exp_addr64_q.pop_front());
          void'(exp_data64_q.pop_front());
        end
      end
      if (exp_addr64_q.size() == 0 && done_cnt > 0) post++;
      tick();
    end
    p_dump_ready = 1'b0;
    checks++; if (exp_addr64_q.size() != 0) begin errors++; $display("FAIL p64_timeout: got %0d beats left expected 0", exp_addr64_q.size()); end
    checks++; if (last_addr !== 4'd15) begin errors++; $display("FAIL p64_last_addr: got %0d expected 15", last_addr); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL p64_done_count: got %0d expected 1", done_cnt); end
    exp_addr64_q.delete();
    exp_data64_q.delete();
  endtask

  task automatic test_reset_mid_dump;
    int seen;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0; dump_ready = 1'b1;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (dump_valid !== 1'b0 || dump_addr !== 5'd0) begin errors++; $display("FAIL abort_state: got valid %b addr %0d expected 0/0", dump_valid, dump_addr); end
    #2 rst = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (dump_done === 1'b1 || dump_valid === 1'b1) seen++;
    end
    dump_ready = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    $display("abort: dump activity cycles after reset %0d", seen);
  endtask

  initial begin
    test_reset();
    test_x0();
    test_scoreboard();
    test_bypass();
    test_dump_backpressure();
    test_param();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
